// File: rtl/rce_enc_pkg.sv
// Shared definitions for the RCE encoder parity path: FSM encoding,
// a constant clog2 helper and the parameter legality check.
package rce_enc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    FULL  = 1'b1
  } fsm_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic bit params_legal(input int m, input int nblk, input int l);
    return (m > 0) && (l > 0) && (nblk >= 1) && ((m % l) == 0);
  endfunction

endpackage

// File: rtl/parity_shift_out.sv
// LSB-first serializer for one captured parity word, M/L beats of L bits
// over a valid/ready handshake.
module parity_shift_out
  import rce_enc_pkg::*;
#(
  parameter int M = 4,
  parameter int L = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [M-1:0] load_data,
  output logic [L-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         empty,
  output logic         last_hs
);

  localparam int BEATS = M / L;
  localparam int BW = clog2(BEATS + 1);
  localparam logic [BW-1:0] BEATS_CNT = BW'(BEATS);

  logic [M-1:0]  shift_reg;
  logic [BW-1:0] beat_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg    <= '0;
      beat_cnt_reg <= '0;
    end else if (load) begin
      shift_reg    <= load_data;
      beat_cnt_reg <= BEATS_CNT;
    end else if (out_valid && out_ready) begin
      shift_reg    <= shift_reg >> L;
      beat_cnt_reg <= beat_cnt_reg - 1'b1;
    end
  end

  // Output is the bottom slice, so it only moves when a beat is consumed.
  always_comb begin
    out_data  = shift_reg[L-1:0];
    out_valid = (beat_cnt_reg != '0);
    out_last  = (beat_cnt_reg == BW'(1));
    empty     = (beat_cnt_reg == '0);
    last_hs   = out_valid && out_last && out_ready;
  end

endmodule

// File: rtl/parity_frame_serializer.sv
// Counts parity beats into the external accumulator, captures and clears it
// at frame end, and hands the word to the serializer.
module parity_frame_serializer
  import rce_enc_pkg::*;
#(
  parameter int M    = 4,
  parameter int NBLK = 4,
  parameter int L    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] acc_q,
  output logic         acc_clr,
  output logic [L-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy
);

  localparam int CNT_W = clog2(NBLK + 1);
  localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(NBLK - 1);

  generate
    if (!params_legal(M, NBLK, L)) begin : g_bad_params
      $error("parity_frame_serializer: need NBLK >= 1 and M divisible by L");
    end
  endgenerate

  fsm_state_t       state_reg, state_next;
  logic [CNT_W-1:0] blk_cnt_reg, blk_cnt_next;
  logic             accept;
  logic             capture;
  logic             shift_empty;
  logic             shift_last_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ACCUM;
      blk_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      blk_cnt_reg <= blk_cnt_next;
    end
  end

  // Capture may coincide with the last beat handshake so frames stream gap-free.
  always_comb begin
    state_next   = state_reg;
    blk_cnt_next = blk_cnt_reg;
    in_ready     = (state_reg == ACCUM) && !rst;
    accept       = in_valid && in_ready;
    capture      = (state_reg == FULL) && !rst && (shift_empty || shift_last_hs);
    case (state_reg)
      ACCUM: begin
        if (accept) begin
          if (blk_cnt_reg == LAST_BLK) begin
            state_next   = FULL;
            blk_cnt_next = '0;
          end else begin
            blk_cnt_next = blk_cnt_reg + 1'b1;
          end
        end
      end
      FULL: begin
        if (capture) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
    acc_clr = rst | capture;
    busy    = !rst && ((blk_cnt_reg != '0) || (state_reg == FULL) || out_valid);
  end

  parity_shift_out #(
    .M(M),
    .L(L)
  ) u_shift_out (
    .clk      (clk),
    .rst      (rst),
    .load     (capture),
    .load_data(acc_q),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .empty    (shift_empty),
    .last_hs  (shift_last_hs)
  );

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Scoreboard bench: a frame-level parity model feeds an expected-beat queue
// that an independent output monitor drains.
module tb_parity_frame_serializer;

  localparam int M = 4;
  localparam int NBLK = 4;
  localparam int L = 1;
  localparam int BEATS = M / L;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [M-1:0] acc_q = '0;
  logic         acc_clr;
  logic [L-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic         busy;
  logic [M-1:0] vec = '0;

  int checks = 0;
  int fails = 0;

  typedef struct {
    logic [L-1:0] data;
    logic         last;
  } beat_t;

  beat_t        exp_q[$];
  logic [M-1:0] frame_par = '0;
  int           frame_cnt = 0;
  beat_t        held;
  bit           held_v = 0;

  always #5 clk = ~clk;

  parity_frame_serializer #(.M(M), .NBLK(NBLK), .L(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .acc_q    (acc_q),
    .acc_clr  (acc_clr),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy)
  );

  // Environment: the XOR accumulator, fed zero unless a beat is accepted.
  always @(posedge clk) begin
    acc_q <= acc_clr ? '0 : (acc_q ^ ((in_valid && in_ready) ? vec : '0));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a frame's parity is the XOR of its NBLK accepted vectors.
  always @(negedge clk) begin
    if (rst) begin
      frame_par = '0;
      frame_cnt = 0;
    end else if (in_valid && in_ready) begin
      frame_par = frame_par ^ vec;
      frame_cnt++;
      if (frame_cnt == NBLK) begin
        for (int k = 0; k < BEATS; k++) begin
          beat_t b;
          b.data = frame_par[k*L +: L];
          b.last = (k == BEATS - 1);
          exp_q.push_back(b);
        end
        frame_par = '0;
        frame_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held_v = 0;
    end else begin
      if (held_v) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(held.data));
        check("hold_last", 32'(out_last), 32'(held.last));
      end
      held_v = 0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_beat: got data %0h with nothing expected at %0t", out_data, $time);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat_data", 32'(out_data), 32'(e.data));
            check("beat_last", 32'(out_last), 32'(e.last));
          end
        end else begin
          held_v = 1;
          held.data = out_data;
          held.last = out_last;
        end
      end
    end
  end

  initial begin
    logic [M-1:0] f1 [4];
    logic [M-1:0] f2 [4];
    logic [3:0]   f1_bits;
    f1[0] = 4'b0001; f1[1] = 4'b0010; f1[2] = 4'b0100; f1[3] = 4'b0001;
    f2[0] = 4'b1000; f2[1] = 4'b0001; f2[2] = 4'b0000; f2[3] = 4'b0000;
    f1_bits = 4'b0110;

    // Reset
    rst = 1'b1;
    tick();
    check("rst_acc_clr", 32'(acc_clr), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_acc_clr", 32'(acc_clr), 32'd0);
    check("rel_out_data", 32'(out_data), 32'd0);

    // Single frame, exact latency
    out_ready = 1'b1;
    for (int i = 0; i < NBLK; i++) begin
      in_valid = 1'b1;
      vec = f1[i];
      tick();
    end
    in_valid = 1'b0;
    vec = '0;
    check("t1_acc_q", 32'(acc_q), 32'(f1_bits));
    check("t1_acc_clr", 32'(acc_clr), 32'd1);
    check("t1_out_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < BEATS; k++) begin
      tick();
      check("sf_valid", 32'(out_valid), 32'd1);
      check("sf_data", 32'(out_data), 32'(f1_bits[k]));
      check("sf_last", 32'(out_last), 32'(k == BEATS - 1));
    end
    tick();
    check("sf_idle_valid", 32'(out_valid), 32'd0);
    check("sf_idle_busy", 32'(busy), 32'd0);

    // Backpressure on frame 1 while frame 2 completes, then ignored input
    for (int i = 0; i < NBLK; i++) begin
      in_valid = 1'b1;
      vec = f1[i];
      tick();
    end
    in_valid = 1'b0;
    vec = '0;
    tick();                                  // t+2: beat 0 handshakes
    in_valid = 1'b1; vec = f2[0];
    tick();                                  // t+3: stall beat 1
    out_ready = 1'b0; vec = f2[1];
    check("bp_data", 32'(out_data), 32'd1);
    tick();
    vec = f2[2];
    tick();
    vec = f2[3];
    tick();                                  // t+6: FULL, frame 1 resumes
    out_ready = 1'b1; vec = 4'hF;
    check("full_in_ready0", 32'(in_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    tick();
    check("full_in_ready1", 32'(in_ready), 32'd0);
    tick();                                  // t+8: last beat + capture
    in_valid = 1'b0; vec = '0;
    check("b2b_last", 32'(out_last), 32'd1);
    check("b2b_capture", 32'(acc_clr), 32'd1);
    tick();
    check("b2b_no_gap_valid", 32'(out_valid), 32'd1);
    check("b2b_no_gap_data", 32'(out_data), 32'd1);
    for (int i = 0; i < NBLK - 1; i++) begin
      in_valid = 1'b1;
      vec = 4'(i + 3);
      tick();
    end
    check("ign_still_accum", 32'(in_ready), 32'd1);
    vec = 4'b0101;
    tick();
    in_valid = 1'b0; vec = '0;
    check("ign_full_after_4", 32'(in_ready), 32'd0);
    repeat (8) tick();

    // Reset during beat 2
    for (int i = 0; i < NBLK; i++) begin
      in_valid = 1'b1;
      vec = f1[i];
      tick();
    end
    in_valid = 1'b0; vec = '0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_acc_clr", 32'(acc_clr), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);

    // Randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      vec = M'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    vec = '0;
    out_ready = 1'b1;
    repeat (30) tick();
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_busy", 32'(busy), 32'(frame_cnt != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/parity_frame_serializer.md
# parity_frame_serializer

Control and output stage directly downstream of the parity accumulator in the parallel RCE encoder. Counts the partial-parity beats folded into the accumulator and detects frame completion. Then captures the accumulated M-bit parity word, clears the accumulator through its synchronous reset, and streams the word out in L-bit beats over a valid/ready interface. Accumulation of the next frame overlaps serialization of the current one.

## Interface
- M, default 4: parity width, equal to the accumulator width.
- NBLK, default 4: accumulation beats per frame, ≥1.
- L, default 1: output beat width; M % L == 0 is required.
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: reset, synchronous, active-high.
- in_valid  in  1: upstream presents a partial-parity vector to the accumulator this cycle.
- in_ready  out  1: beat is counted only when in_valid && in_ready.
- acc_q  in  M: accumulator output (q).
- acc_clr  out  M/A (1): drives the accumulator rst pin.
- out_data  out  L: current parity beat.
- out_valid  out  1: out_data is valid.
- out_ready  in  1: downstream accepts the beat.
- out_last  out  1: final beat of the frame.
- busy  out  1: frame partially accumulated or serializer non-empty.

## Operation
- Upstream contract: the accumulator input must be all-zero whenever !(in_valid && in_ready), because the accumulator XORs every cycle with no enable.
- FSM, two states:
  - ACCUM: in_ready=1. Each accepted beat increments blk_cnt (width $clog2(NBLK+1)). Accepting beat number NBLK moves the FSM to FULL and resets blk_cnt to 0.
  - FULL: in_ready=0. Capture is allowed when the shifter is empty, or when the shifter's final beat handshakes this cycle (out_valid && out_last && out_ready).
  - On capture: load acc_q into the shift register, assert acc_clr for this cycle, and return to ACCUM.
  - If capture is not allowed, stay in FULL. acc_q remains stable because the accumulator input is zero.
- acc_clr = rst | capture. This output is combinational.
- Serializer:
  - Holds an M-bit shift register and a beat counter, beats = M/L.
  - Emits LSB-first: beat k is word[k*L +: L].
  - out_valid=1 while the beat count is >0. The counter advances only on out_valid && out_ready.
  - out_data and out_last are held stable while out_valid && !out_ready.
- in_valid while in_ready=0 is ignored and not counted.
- busy = (blk_cnt != 0) | (state==FULL) | out_valid.

## Timing
- Reset values:
  - in_ready=0 while rst=1, and 1 in the first cycle after release.
  - acc_clr=1 while rst=1.
  - out_valid=0, out_last=0, out_data=0, busy=0.
  - State returns to ACCUM, blk_cnt=0, shifter cleared.
- The last input beat is accepted at cycle t. acc_q holds the final parity at t+1, which is the earliest capture and acc_clr cycle. The first out_valid is at t+2.
- Accumulator reads zero at t+2. The next frame's first beat may be accepted at t+2.
- Back-to-back capture on the final-beat handshake gives no output bubble.
- Minimum frame period: max(NBLK+1, M/L) cycles.
- NBLK=1: every accepted beat is followed by FULL.
- Reset mid-frame or mid-serialization drops the in-flight frame. out_valid deasserts in the cycle after rst is sampled.

## Structure
- Shared package `rce_enc_pkg` holds:
  - the FSM state encoding (ACCUM, FULL);
  - a clog2 helper;
  - the M/NBLK/L legality check (M % L == 0, NBLK ≥ 1).
- One sub-module: `parity_shift_out`, parameters M and L. It contains the shift register, beat counter, and valid/last logic, with load, load_data, and an empty/last-handshake indication. The top level holds the FSM and blk_cnt.

## Test plan
Parameters for all scenarios: M=4, NBLK=4, L=1.
- Reset: rst=1 for 2 cycles -> acc_clr=1, in_ready=0, out_valid=0, busy=0. Cycle after release -> in_ready=1, acc_clr=0.
- Single frame: accumulator inputs 4'b0001, 4'b0010, 4'b0100, 4'b0001 with in_valid -> acc_q=4'b0110 at t+1, acc_clr=1 that cycle. With out_ready=1, out_data=0,1,1,0 at t+2..t+5, out_last only at t+5.
- Backpressure: out_ready=0 for 3 cycles at beat 1 -> out_data=1 and out_valid=1 held, sequence still 0,1,1,0, no duplicated or lost beat.
- Back-to-back: second frame (parity 4'b1001) completes while frame 1 is stalled -> FSM in FULL, in_ready=0. Capture coincides with frame 1's last handshake, and the next cycle emits 1,0,0,1 with no gap.
- Ignored input: in_valid=1 during FULL for 2 cycles -> blk_cnt unchanged, next frame still needs 4 accepted beats.
- Mid-serialization reset: rst during beat 2 -> out_valid=0 the next cycle, acc_clr=1, busy=0 after release, and a fresh frame then serializes correctly.
